// File: rtl/aes_spi_host_ctrl.sv
// Sequences one AES job as a key frame then a data frame through the SPI main, returning the received word.
// Latency: illegal key_len responds the cycle after accept; legal jobs take two frames plus two gaps.
// Backpressure: in_ready only in IDLE; result held in RESP until out_ready, no same-cycle re-accept.
module aes_spi_host_ctrl #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   key_len,
    input  logic [0:255] key,
    input  logic [0:127] block,
    input  logic         dev_sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         out_err,
    output logic         spi_start,
    output logic         spi_sel,
    output logic [0:257] spi_tx,
    input  logic [0:127] spi_rx,
    input  logic         spi_done
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, KEY_START, KEY_WAIT_LO, KEY_WAIT_HI, GAP,
        DAT_START, DAT_WAIT_LO, DAT_WAIT_HI, GAP2, RESP
    } state_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  tmo_cnt;
    logic [GW-1:0]  gap_cnt;
    logic [0:127]   block_r;
    logic           tmo_hit, gap_last, tmo_abort, in_wait;

    assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign gap_last  = (gap_cnt == GW'(GAP_CYCLES - 1));
    assign in_wait   = (state == KEY_WAIT_LO) || (state == KEY_WAIT_HI) ||
                       (state == DAT_WAIT_LO) || (state == DAT_WAIT_HI);
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == RESP);
    assign spi_start = (state == KEY_START) || (state == DAT_START);

    // A frame completes only on done rising after it was seen low post-start;
    // a stale done level from the previous frame is never taken as completion.
    always_comb begin
        state_nxt = state;
        tmo_abort = 1'b0;
        case (state)
            IDLE:        if (in_valid) state_nxt = (key_len == 2'b11) ? RESP : KEY_START;
            KEY_START:   state_nxt = KEY_WAIT_LO;
            KEY_WAIT_LO: if (!spi_done) state_nxt = KEY_WAIT_HI;
                         else if (tmo_hit) begin state_nxt = GAP2; tmo_abort = 1'b1; end
            KEY_WAIT_HI: if (spi_done) state_nxt = GAP;
                         else if (tmo_hit) begin state_nxt = GAP2; tmo_abort = 1'b1; end
            GAP:         if (gap_last) state_nxt = DAT_START;
            DAT_START:   state_nxt = DAT_WAIT_LO;
            DAT_WAIT_LO: if (!spi_done) state_nxt = DAT_WAIT_HI;
                         else if (tmo_hit) begin state_nxt = GAP2; tmo_abort = 1'b1; end
            DAT_WAIT_HI: if (spi_done) state_nxt = GAP2;
                         else if (tmo_hit) begin state_nxt = GAP2; tmo_abort = 1'b1; end
            GAP2:        if (gap_last) state_nxt = RESP;
            RESP:        if (out_ready) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tmo_cnt  <= '0;
            gap_cnt  <= '0;
            block_r  <= '0;
            spi_sel  <= 1'b0;
            spi_tx   <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (spi_start)    tmo_cnt <= '0;
            else if (in_wait) tmo_cnt <= tmo_cnt + TW'(1);

            if (state == GAP || state == GAP2) gap_cnt <= gap_cnt + GW'(1);
            else                               gap_cnt <= '0;

            // Key frame is built straight from the accepted inputs so it is
            // on spi_tx in the same cycle as the first start pulse.
            if (state == IDLE && in_valid) begin
                block_r  <= block;
                spi_sel  <= dev_sel;
                out_data <= '0;
                out_err  <= (key_len == 2'b11);
                case (key_len)
                    2'b00:   spi_tx <= {2'b00, 128'b0, key[0:127]};
                    2'b01:   spi_tx <= {2'b01, 64'b0, key[0:191]};
                    2'b10:   spi_tx <= {2'b10, key};
                    default: spi_tx <= '0;
                endcase
            end

            if (state == GAP && gap_last)
                spi_tx <= {2'b00, 128'b0, block_r};

            if (state == DAT_WAIT_HI && spi_done)
                out_data <= spi_rx;

            if (tmo_abort) begin
                out_err  <= 1'b1;
                out_data <= '0;
            end

            if (state == RESP && out_ready)
                spi_sel <= 1'b0;
        end
    end
endmodule

// File: tb/tb_aes_spi_host_ctrl.sv
// Directed bench for aes_spi_host_ctrl with a behavioural SPI main model.
module tb_aes_spi_host_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   key_len = 2'b00;
    logic [0:255] key = '0;
    logic [0:127] block = '0;
    logic         dev_sel = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [0:127] out_data;
    logic         out_err;
    logic         spi_start;
    logic         spi_sel;
    logic [0:257] spi_tx;
    logic [0:127] spi_rx;
    logic         spi_done = 1'b1;

    int checks = 0;
    int failures = 0;

    // SPI main model knobs
    int lo_dly = 0;
    int hi_dly = 2;
    logic never = 1'b0;
    int ph = 0;
    int cnt = 0;
    int nstarts = 0;
    logic [0:257] tx_q[$];
    logic sel_q[$];
    logic [0:127] rx_word = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_43EF;

    assign spi_rx = rx_word;

    aes_spi_host_ctrl #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .key_len(key_len), .key(key), .block(block), .dev_sel(dev_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .spi_start(spi_start), .spi_sel(spi_sel),
        .spi_tx(spi_tx), .spi_rx(spi_rx), .spi_done(spi_done)
    );

    always #5 clk = ~clk;

    // done drops lo_dly edges after start is sampled, rises hi_dly+1 edges later
    always @(posedge clk) begin
        if (spi_start) begin
            nstarts <= nstarts + 1;
            tx_q.push_back(spi_tx);
            sel_q.push_back(spi_sel);
            if (lo_dly == 0) begin
                spi_done <= 1'b0; ph <= 2; cnt <= hi_dly;
            end else begin
                ph <= 1; cnt <= lo_dly - 1;
            end
        end else if (ph == 1) begin
            if (cnt == 0) begin spi_done <= 1'b0; ph <= 2; cnt <= hi_dly; end
            else cnt <= cnt - 1;
        end else if (ph == 2 && !never) begin
            if (cnt == 0) begin spi_done <= 1'b1; ph <= 0; end
            else cnt <= cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [257:0] got, input logic [257:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_job(input string tag, input logic [1:0] kl, input logic [0:255] k,
                           input logic [0:127] b, input logic ds, input int rdy_wait,
                           input int exp_lat, input logic [0:127] exp_dat,
                           input logic exp_err, input int exp_starts);
        int n;
        int lat;
        tx_q.delete();
        sel_q.delete();
        @(negedge clk);
        key_len = kl; key = k; block = b; dev_sel = ds; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        check({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; key_len = ~kl; key = ~k; block = ~b; dev_sel = ~ds;
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, out_data, exp_dat);
        check({tag, "_err"}, out_err, exp_err);
        for (int i = 0; i < rdy_wait; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, out_valid, 1'b1);
            check({tag, "_hold_data"}, out_data, exp_dat);
            check({tag, "_hold_in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_xfer_valid"}, out_valid, 1'b0);
        check({tag, "_xfer_in_ready"}, in_ready, 1'b1);
        check({tag, "_starts"}, tx_q.size(), exp_starts);
    endtask

    initial begin
        logic [0:255] k128, k256;
        logic [0:127] blk_a, blk_5;
        logic [0:257] exp;
        int n;

        k128 = '0;
        for (int i = 0; i < 16; i++) k128[8*i +: 8] = 8'(i);
        k256 = {64'h0011_2233_4455_6677, 64'h8899_AABB_CCDD_EEFF,
                64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978};
        blk_a = {16{8'hAA}};
        blk_5 = {16{8'h5A}};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_spi_start", spi_start, 1'b0);
        check("rst_spi_sel", spi_sel, 1'b0);
        check("rst_spi_tx", spi_tx, '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_err", out_err, 1'b0);
        @(negedge clk); rst = 1'b0;
        #1 check("idle_in_ready", in_ready, 1'b1);

        // 128-bit key, done held high from an earlier frame at start
        run_job("k128", 2'b00, k128, blk_a, 1'b0, 0, 14, rx_word, 1'b0, 2);
        exp = '0; exp[130:257] = k128[0:127];
        if (tx_q.size() == 2) begin
            check("k128_keyframe", tx_q[0], exp);
            exp = '0; exp[130:257] = blk_a;
            check("k128_datframe", tx_q[1], exp);
            check("k128_sel", sel_q[0], 1'b0);
        end

        // 256-bit key
        run_job("k256", 2'b10, k256, blk_5, 1'b1, 0, 14, rx_word, 1'b0, 2);
        exp = '0; exp[0:1] = 2'b10; exp[2:257] = k256;
        if (tx_q.size() > 0) begin
            check("k256_keyframe", tx_q[0], exp);
            check("k256_sel", sel_q[0], 1'b1);
        end

        // 192-bit key, unused key tail must not leak
        run_job("k192", 2'b01, k256, blk_5, 1'b0, 0, 14, rx_word, 1'b0, 2);
        exp = '0; exp[0:1] = 2'b01; exp[66:257] = k256[0:191];
        if (tx_q.size() > 0) check("k192_keyframe", tx_q[0], exp);

        // illegal key length: immediate error response, no SPI traffic
        run_job("kill", 2'b11, k256, blk_a, 1'b0, 0, 0, '0, 1'b1, 0);

        // done never rises: 16 wait cycles + 2 gap cycles after start edge
        never = 1'b1;
        run_job("tmo", 2'b00, k128, blk_a, 1'b0, 0, 19, '0, 1'b1, 1);
        never = 1'b0;

        // done lingers high 3 cycles past start; result backpressured 5 cycles
        lo_dly = 3;
        run_job("slow", 2'b00, k128, blk_a, 1'b1, 5, 20, rx_word, 1'b0, 2);
        lo_dly = 0;

        // reset during the data frame's wait for done
        hi_dly = 6;
        tx_q.delete(); sel_q.delete();
        n = nstarts;
        @(negedge clk);
        key_len = 2'b00; key = k128; block = blk_a; dev_sel = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        for (int i = 0; i < 100 && nstarts != n + 2; i++) begin @(posedge clk); #1; end
        check("mid_starts", nstarts - n, 2);
        @(posedge clk); #1;
        check("mid_sel_before", spi_sel, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_in_ready", in_ready, 1'b0);
        check("mid_out_valid", out_valid, 1'b0);
        check("mid_spi_start", spi_start, 1'b0);
        check("mid_spi_sel", spi_sel, 1'b0);
        check("mid_spi_tx", spi_tx, '0);
        check("mid_out_data", out_data, '0);
        check("mid_out_err", out_err, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        hi_dly = 2;
        run_job("post", 2'b00, k128, blk_5, 1'b1, 0, 14, rx_word, 1'b0, 2);
        if (sel_q.size() == 2) begin
            check("post_sel_key", sel_q[0], 1'b1);
            check("post_sel_dat", sel_q[1], 1'b1);
            exp = '0; exp[130:257] = blk_5;
            check("post_datframe", tx_q[1], exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
